// File: rtl/cu_pkg.sv
// Shared definitions for the CU arbiter: opcode encoding and FSM state type.
package cu_pkg;

  typedef enum logic [1:0] {
    CU_SUB = 2'b00,
    CU_CMP = 2'b01,
    CU_ADD = 2'b10,
    CU_MUL = 2'b11
  } cu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } cu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: priority starts at the requester after the last grant and wraps.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         grant
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    grant = '0;
    idx   = '0;
    // Walk from lowest to highest priority; the last requester found wins.
    for (int off = N_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last) + off) % N_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_arbiter.sv
// Shares one registered compute unit among N_REQ requesters, one operation in flight.
// Optional macro CU_ARB_PERF_EN implements the perf_ops completed-operation counter.
module cu_arbiter
  import cu_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*DATA_W-1:0]  req_par,
  input  logic [N_REQ*2-1:0]       req_sel,
  output logic [DATA_W-1:0]        cu_data,
  output logic [DATA_W-1:0]        cu_par,
  output logic [1:0]               cu_sel,
  output logic                     cu_is_output,
  input  logic [DATA_W-1:0]        cu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [15:0]              perf_ops
);
  localparam int IDX_W = $clog2(N_REQ);

  cu_state_e         state;
  logic [IDX_W-1:0]  last_grant;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] win_par;
  logic [1:0]        win_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Acceptance is combinational so the winner sees req_ready in the cycle its operands are latched.
  assign accept    = (state == IDLE) && !rst && (grant != '0);
  assign req_ready = accept ? grant : '0;

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    win_par  = '0;
    win_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = IDX_W'(i);
        win_data = req_data[i*DATA_W +: DATA_W];
        win_par  = req_par[i*DATA_W +: DATA_W];
        win_sel  = req_sel[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(N_REQ - 1);
      cu_is_output <= 1'b0;
      cu_data      <= '0;
      cu_par       <= '0;
      cu_sel       <= CU_SUB;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      cu_is_output <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant   <= win_idx;
            rsp_id       <= win_idx;
            cu_data      <= win_data;
            cu_par       <= win_par;
            cu_sel       <= win_sel;
            cu_is_output <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_data  <= cu_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef CU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops <= '0;
    end else if (state == RESP && rsp_ready && perf_ops != 16'hFFFF) begin
      perf_ops <= perf_ops + 16'd1;
    end
  end
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_cu_arbiter.sv
// Scoreboard bench for cu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Define CU_ARB_PERF_EN for both bench and RTL to check the perf_ops counter.
module tb_cu_arbiter;
  import cu_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data;
  logic [N*W-1:0]   req_par;
  logic [N*2-1:0]   req_sel;
  logic [W-1:0]     cu_data;
  logic [W-1:0]     cu_par;
  logic [1:0]       cu_sel;
  logic             cu_is_output;
  logic [W-1:0]     cu_out = '0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  logic [15:0]      perf_ops;

  always #5 clk = ~clk;

  cu_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_par      (req_par),
    .req_sel      (req_sel),
    .cu_data      (cu_data),
    .cu_par       (cu_par),
    .cu_sel       (cu_sel),
    .cu_is_output (cu_is_output),
    .cu_out       (cu_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .perf_ops     (perf_ops)
  );

  function automatic logic [W-1:0] cu_fn(input logic [W-1:0] d, input logic [W-1:0] p,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return d - p;
      2'b01:   return (d > p) ? W'(1) : W'(0);
      2'b10:   return d + p;
      default: return d * p;
    endcase
  endfunction

  // Registered compute unit: result appears one cycle after the strobe.
  always @(posedge clk) if (cu_is_output) cu_out <= cu_fn(cu_data, cu_par, cu_sel);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester-side stimulus state; applied to the DUT on each falling edge.
  logic         pend [N];
  logic [W-1:0] rd   [N];
  logic [W-1:0] rp   [N];
  logic [1:0]   rs   [N];
  logic         nrst;
  logic         nrr;
  logic [N-1:0] acc;

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [W-1:0] p,
                         input logic [1:0] s);
    pend[i] = 1'b1; rd[i] = d; rp[i] = p; rs[i] = s;
  endtask

  function automatic logic [W-1:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
  endfunction

  task automatic apply();
    rst       = nrst;
    rsp_ready = nrr;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_data[i*W +: W]  = rd[i];
      req_par[i*W +: W]   = rp[i];
      req_sel[i*2 +: 2]   = rs[i];
    end
  endtask

  // One cycle: drive on the falling edge, sample handshakes shortly after.
  task automatic cyc_step();
    @(negedge clk);
    apply();
    #2;
    acc = req_ready & req_valid;
    for (int i = 0; i < N; i++) if (acc[i]) pend[i] = 1'b0;
  endtask

  task automatic wait_grant(input int i);
    int k;
    k = 0;
    do begin
      cyc_step();
      k++;
    end while (!acc[i] && k < 12);
    check($sformatf("grant_req%0d", i), 64'(acc[i]), 64'd1);
  endtask

  // Reference model and scoreboard, updated by the monitor.
  typedef struct {
    int           id;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb [$];
  exp_t         e;
  int           g_id  [$];
  int           g_cyc [$];
  int           cyc    = 0;
  int           m_ptr  = N - 1;
  bit           m_busy = 1'b0;
  int           m_gcyc = -100;
  int           m_done = 0;
  logic [W-1:0] m_cd = '0;
  logic [W-1:0] m_cp = '0;
  logic [1:0]   m_cs = '0;
  int           mon_w;
  logic [N-1:0] mon_exp;

  task automatic drain();
    int k;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    nrr = 1'b1;
    k = 0;
    while (m_busy && k < 30) begin
      cyc_step();
      k++;
    end
    cyc_step();
    check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      check("ready_in_reset", 64'(req_ready), 64'd0);
      m_busy = 1'b0; m_ptr = N - 1; m_done = 0; sb.delete();
      m_cd = '0; m_cp = '0; m_cs = '0;
    end else begin
      mon_w   = -1;
      mon_exp = '0;
      if (!m_busy)
        for (int k = 1; k <= N; k++)
          if (mon_w < 0 && req_valid[(m_ptr + k) % N]) mon_w = (m_ptr + k) % N;
      if (mon_w >= 0) mon_exp[mon_w] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(mon_exp));
      check("cu_data", 64'(cu_data), 64'(m_cd));
      check("cu_par", 64'(cu_par), 64'(m_cp));
      check("cu_sel", 64'(cu_sel), 64'(m_cs));
      check("cu_is_output", 64'(cu_is_output), 64'(m_busy && cyc == m_gcyc + 1));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy && cyc >= m_gcyc + 3));
      if (m_busy && cyc >= m_gcyc + 3 && sb.size() > 0) begin
        check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        check("rsp_data", 64'(rsp_data), 64'(sb[0].res));
        if (rsp_ready) begin
          void'(sb.pop_front());
          m_done++;
          m_busy = 1'b0;
        end
      end
`ifdef CU_ARB_PERF_EN
      check("perf_ops", 64'(perf_ops), (m_done > 65535) ? 64'd65535 : 64'(m_done));
`else
      check("perf_ops", 64'(perf_ops), 64'd0);
`endif
      if (mon_w >= 0) begin
        m_cd  = req_data[mon_w*W +: W];
        m_cp  = req_par[mon_w*W +: W];
        m_cs  = req_sel[mon_w*2 +: 2];
        e.id  = mon_w;
        e.res = cu_fn(m_cd, m_cp, m_cs);
        sb.push_back(e);
        m_busy = 1'b1;
        m_gcyc = cyc;
        m_ptr  = mon_w;
        g_id.push_back(mon_w);
        g_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_data = '0; req_par = '0; req_sel = '0;
    nrst = 1'b1; nrr = 1'b1; acc = '0;
    // Requests held during reset must not be accepted.
    for (int i = 0; i < N; i++) set_req(i, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
    repeat (3) cyc_step();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    nrst = 1'b0;
    cyc_step();
    check("rst_cu_is_output", 64'(cu_is_output), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_cu_data", 64'(cu_data), 64'd0);
    check("rst_cu_par", 64'(cu_par), 64'd0);
    check("rst_cu_sel", 64'(cu_sel), 64'd0);
    check("rst_perf_ops", 64'(perf_ops), 64'd0);

    // Single requester: 7 - 3, latency 3.
    set_req(0, 32'd7, 32'd3, CU_SUB);
    wait_grant(0);
    check("b_ready", 64'(req_ready), 64'b0001);
    cyc_step();
    check("b_strobe", 64'(cu_is_output), 64'd1);
    check("b_cu_data", 64'(cu_data), 64'd7);
    cyc_step();
    check("b_no_rsp_yet", 64'(rsp_valid), 64'd0);
    cyc_step();
    check("b_rsp_valid", 64'(rsp_valid), 64'd1);
    check("b_rsp_id", 64'(rsp_id), 64'd0);
    check("b_rsp_data", 64'(rsp_data), 64'd4);
    drain();

    // All requesters continuously valid after reset: order 0,1,2,3,0, four cycles apart.
    nrst = 1'b1; cyc_step(); nrst = 1'b0;
    g_id.delete(); g_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
    repeat (24) begin
      cyc_step();
      for (int i = 0; i < N; i++) if (acc[i]) set_req(i, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
    end
    check("c_grant_count_ge5", 64'(g_id.size() >= 5), 64'd1);
    if (g_id.size() >= 5) begin
      for (int j = 0; j < 5; j++) check($sformatf("c_order%0d", j), 64'(g_id[j]), 64'(j % N));
      for (int j = 0; j < 4; j++) check($sformatf("c_gap%0d", j), 64'(g_cyc[j+1] - g_cyc[j]), 64'd4);
    end
    drain();

    // Backpressure on 6*7 with other requesters waiting.
    nrr = 1'b0;
    set_req(2, 32'd6, 32'd7, CU_MUL);
    wait_grant(2);
    set_req(0, rnd_val(), rnd_val(), CU_ADD);
    set_req(1, rnd_val(), rnd_val(), CU_CMP);
    set_req(3, rnd_val(), rnd_val(), CU_SUB);
    k = 0;
    while (!rsp_valid && k < 10) begin cyc_step(); k++; end
    repeat (5) begin
      check("d_rsp_held", 64'(rsp_valid), 64'd1);
      check("d_rsp_data", 64'(rsp_data), 64'd42);
      check("d_no_ready", 64'(req_ready), 64'd0);
      cyc_step();
    end
    nrr = 1'b1;
    cyc_step();
    check("d_handshake_no_ready", 64'(req_ready), 64'd0);
    cyc_step();
    check("d_next_grant", 64'(req_ready), 64'b1000);
    drain();

    // Reset during CAPTURE abandons the operation.
    set_req(1, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
    wait_grant(1);
    cyc_step();
    nrst = 1'b1;
    cyc_step();
    check("e_capture_no_rsp", 64'(rsp_valid), 64'd0);
    nrst = 1'b0;
    set_req(0, rnd_val(), rnd_val(), CU_ADD);
    set_req(3, rnd_val(), rnd_val(), CU_ADD);
    cyc_step();
    check("e_rsp_valid_after_rst", 64'(rsp_valid), 64'd0);
    check("e_idle_grant", 64'(req_ready), 64'b0001);
    check("e_no_strobe", 64'(cu_is_output), 64'd0);
    drain();

    // Three completed operations after reset.
    nrst = 1'b1; cyc_step(); nrst = 1'b0;
    set_req(3, 32'd5, 32'd2, CU_CMP); wait_grant(3); drain();
    set_req(3, 32'd1, 32'd1, CU_ADD); wait_grant(3); drain();
    set_req(3, 32'd0, 32'd1, CU_SUB); wait_grant(3); drain();
`ifdef CU_ARB_PERF_EN
    check("f_perf_ops", 64'(perf_ops), 64'd3);
`else
    check("f_perf_ops", 64'(perf_ops), 64'd0);
`endif

    // Randomized traffic with drops, backpressure and occasional reset.
    for (int c = 0; c < 900; c++) begin
      nrst = ($urandom_range(0, 299) == 0);
      nrr  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 99) < 30) set_req(i, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 99) < 4) begin
          pend[i] = 1'b0;
        end
      end
      cyc_step();
    end
    nrst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cu_arbiter.md
CU_ARBITER -- requirements
Module: cu_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one computer unit (CU); legal range 2..8.
REQ-002 Parameter DATA_W, default 32: operand and result width.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 req_valid  in  N_REQ  per-requester operation request.
REQ-006 req_ready  out  N_REQ  one-hot acceptance pulse to the granted requester.
REQ-007 req_data  in  N_REQ*DATA_W  per-requester first operand, packed with requester i at [i*DATA_W +: DATA_W].
REQ-008 req_par  in  N_REQ*DATA_W  per-requester second operand (weight), packed the same way.
REQ-009 req_sel  in  N_REQ*2  per-requester opcode: 00 sub, 01 compare-greater, 10 add, 11 multiply.
REQ-010 cu_data, cu_par  out  DATA_W each  operands driven to the CU.
REQ-011 cu_sel  out  2  opcode driven to the CU.
REQ-012 cu_is_output  out  1  CU enable strobe.
REQ-013 cu_out  in  DATA_W  CU result, registered in the CU and valid one cycle after the strobe.
REQ-014 rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  $clog2(N_REQ), rsp_data  out  DATA_W: result return channel.
REQ-015 perf_ops  out  16  count of completed operations.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-017 IDLE: if any req_valid is high, pick a winner round-robin starting at the index after the last grant. In the same cycle, pulse req_ready for the winner only, latch its data/par/sel/id, and go to ISSUE. Otherwise stay in IDLE.
REQ-018 ISSUE: drive the latched operands and opcode with cu_is_output=1 for exactly one cycle, then go to CAPTURE.
REQ-019 CAPTURE: register cu_out into rsp_data, then go to RESP.
REQ-020 RESP: hold rsp_valid=1 with rsp_id and rsp_data stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-021 Minimum latency SHALL be 3 cycles from the req_ready pulse to the first rsp_valid. Minimum acceptance interval SHALL be 4 cycles.
REQ-022 cu_is_output SHALL be 0 in every state except ISSUE. cu_data, cu_par and cu_sel SHALL hold their last values when the strobe is low.
REQ-023 At most one request SHALL be outstanding. req_ready SHALL be 0 in all states except IDLE.
REQ-024 The round-robin pointer SHALL update only on a grant. After granting requester k, priority order is k+1, ..., N_REQ-1, 0, ..., k, with wrap-around.
REQ-025 A req_valid deasserted before it is granted SHALL be dropped without side effects. Requests arriving while busy SHALL wait; none is lost while its valid is held.
REQ-026 perf_ops SHALL increment on each RESP handshake and saturate at 16'hFFFF.
REQ-027 No arithmetic SHALL be performed in this block; rsp_data is cu_out unmodified.

Reset
REQ-028 While rst is high, at every clk edge: state=IDLE, pointer=N_REQ-1 (requester 0 has first priority), and req_ready, cu_is_output, rsp_valid, rsp_id, rsp_data, cu_data, cu_par, cu_sel and perf_ops all 0.
REQ-029 rst asserted mid-operation SHALL abandon the in-flight operation. No response is produced, and the CU result of an already-issued strobe SHALL be ignored.

Configuration
REQ-030 Macro CU_ARB_PERF_EN: when defined, the perf_ops counter is implemented per REQ-026. When undefined, perf_ops SHALL be tied to 0, no counter flops are inferred, and the port list is unchanged.

Structure
REQ-031 Shared package cu_pkg SHALL hold the opcode constants (CU_SUB=2'b00, CU_CMP=2'b01, CU_ADD=2'b10, CU_MUL=2'b11) and the FSM state typedef.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req and last-grant pointer, and output one-hot grant.

Verification
REQ-033 Single requester: req0 data=7, par=3, sel=00 -> req_ready[0] at cycle T, cu_is_output at T+1, rsp_valid at T+3 with rsp_id=0 and rsp_data=4.
REQ-034 All four requesters valid continuously after reset, rsp_ready=1 -> grant order 0,1,2,3,0 with grants 4 cycles apart.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles on a mul 6*7 -> rsp_valid held, rsp_data=42 stable, no new req_ready until the handshake.
REQ-036 Reset mid-operation: rst for 1 cycle in CAPTURE -> next cycle state IDLE, rsp_valid=0, and no response for that request.
REQ-037 With CU_ARB_PERF_EN, 3 completed ops (cmp 5>2 -> 1, add 1+1 -> 2, sub 0-1 -> 32'hFFFFFFFF) -> perf_ops=3. Without the macro -> perf_ops=0.
